// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one byte per frame, sends start, 8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx_serializer #(
    parameter int CLK_PER_HALF_BIT = 86
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int unsigned CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_CYC - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at accept because the shift register is consumed while sending.
    logic             parity;
`endif

    always_comb begin
        bit_done = (cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        shreg    <= in_data;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^in_data;
`endif
                        cnt      <= CNT_RELOAD;
                        state    <= START;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        txd     <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= '0;
                        cnt     <= CNT_RELOAD;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt <= CNT_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= parity;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        cnt   <= CNT_RELOAD;
                        state <= STOP;
                        txd   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-level reference model checked every cycle, plus literal frames.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_serializer;

    localparam int CHB     = 4;
    localparam int BIT_CYC = 2 * CHB;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam logic [FRAME_BITS-1:0] LIT_55 = 11'b10010101010;
    localparam logic [FRAME_BITS-1:0] LIT_81 = 11'b10100000010;
    localparam logic [FRAME_BITS-1:0] LIT_07 = 11'b11000001110;
    localparam logic [FRAME_BITS-1:0] LIT_03 = 11'b10000000110;
`else
    localparam int FRAME_BITS = 10;
    localparam logic [FRAME_BITS-1:0] LIT_55 = 10'b1010101010;
    localparam logic [FRAME_BITS-1:0] LIT_81 = 10'b1100000010;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       txd;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_PER_HALF_BIT(CHB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .txd      (txd),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole frame as the line must show it, index 0 transmitted first.
    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] d);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        f[FRAME_BITS-1] = 1'b1;
        return f;
    endfunction

    // Reference model: position within the current frame, advanced once per clock.
    bit                    m_active = 1'b0;
    bit                    m_rdy    = 1'b0;
    int                    m_pos    = 0;
    logic [FRAME_BITS-1:0] m_frame  = '1;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_rdy    <= 1'b0;
            m_pos    <= 0;
        end else if (m_active) begin
            m_pos <= m_pos + 1;
            if (m_pos + 1 == FRAME_CYC) m_active <= 1'b0;
        end else if (m_rdy && in_valid) begin
            m_active <= 1'b1;
            m_pos    <= 0;
            m_frame  <= frame_of(in_data);
        end else begin
            m_rdy <= 1'b1;
        end
    end

    logic e_txd, e_busy, e_rdy;

    always @(negedge clk) begin
        if (rst) begin
            e_txd = 1'b1; e_busy = 1'b0; e_rdy = 1'b0;
        end else if (m_active) begin
            e_txd = m_frame[m_pos / BIT_CYC]; e_busy = 1'b1; e_rdy = 1'b0;
        end else begin
            e_txd = 1'b1; e_busy = 1'b0; e_rdy = m_rdy;
        end
        check("mon_txd", txd, e_txd);
        check("mon_busy", busy, e_busy);
        check("mon_in_ready", in_ready, e_rdy);
    end

    // Called at posedge+1 with the serializer idle; leaves the bench at posedge+1 after accept.
    task automatic accept_byte(input logic [7:0] d, input bit keep);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic capture_frame(output logic [FRAME_BITS-1:0] got);
        got = '0;
        for (int k = 1; k <= FRAME_CYC; k++) begin
            @(negedge clk);
            if (k == 1) check("start_latency", txd, 1'b0);
            if (k == FRAME_CYC) check("busy_last_cycle", busy, 1'b1);
            if ((k - 1) % BIT_CYC == BIT_CYC / 2) got[(k-1) / BIT_CYC] = txd;
        end
        @(negedge clk);
        check("end_busy", busy, 1'b0);
        check("end_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!m_active && m_rdy && !rst) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("wait_idle_timeout", ok, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FRAME_BITS-1:0] got;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", txd, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", in_ready, 1'b1);

        accept_byte(8'h55, 1'b0);
        capture_frame(got);
        check("frame_55", got, LIT_55);

        // Held valid: second byte goes out after exactly one idle-high cycle.
        accept_byte(8'hA5, 1'b1);
        in_data = 8'h3C;
        repeat (FRAME_CYC) @(negedge clk);
        @(negedge clk);
        check("gap_txd", txd, 1'b1);
        check("gap_in_ready", in_ready, 1'b1);
        @(negedge clk);
        check("b2b_start_txd", txd, 1'b0);
        check("b2b_busy", busy, 1'b1);
        in_valid = 1'b0;
        wait_idle();

        accept_byte(8'h96, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        check("midframe_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
        repeat (20) @(posedge clk);
        #1;

        // Reset during data bit 3 of 0x00 must take the line high without waiting for a clock.
        accept_byte(8'h00, 1'b0);
        repeat (36) @(negedge clk);
        check("bit3_txd", txd, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_txd", txd, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        accept_byte(8'h81, 1'b0);
        capture_frame(got);
        check("frame_81", got, LIT_81);

`ifdef UART_TX_PARITY_EN
        accept_byte(8'h07, 1'b0);
        capture_frame(got);
        check("frame_07", got, LIT_07);
        check("parity_07", got[9], 1'b1);
        accept_byte(8'h03, 1'b0);
        capture_frame(got);
        check("frame_03", got, LIT_03);
        check("parity_03", got[9], 1'b0);
`endif

        repeat (3000) begin
            @(posedge clk);
            #1;
            rst      = ($urandom_range(0, 699) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
